// File: rtl/sram_arbiter_ctrl.sv
// Round-robin arbiter and access sequencer for the board's asynchronous 16-bit SRAM,
// shared by the CPU memory port (requester 0) and the loader/debug port (requester 1).
module sram_arbiter_ctrl #(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 20
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [15:0]       cpu_wdata,
  output logic [15:0]       cpu_rdata,
  output logic              cpu_ready,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [15:0]       ld_wdata,
  output logic [15:0]       ld_rdata,
  output logic              ld_ready,
  output logic              grant,
  output logic              busy,
  output logic [ADDR_W-1:0] A,
  output logic              CE_out,
  output logic              OE_out,
  output logic              WE_out,
  output logic              UB_out,
  output logic              LB_out,
  inout  wire  [15:0]       Mem_bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_DONE
  } state_t;

  localparam int               CNT_W    = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              grant_q, grant_d;
  logic              last_grant_q, last_grant_d;
  logic              busy_q, busy_d;
  logic              ce_q, ce_d;
  logic              oe_q, oe_d;
  logic              wen_q, wen_d;
  logic              ub_q, ub_d;
  logic              lb_q, lb_d;

  logic [1:0]        req_vec;
  logic [1:0]        we_vec;
  logic [ADDR_W-1:0] addr_vec  [2];
  logic [15:0]       wdata_vec [2];
  logic              any_req;
  logic              winner;
  logic              access_last;
  logic              bus_oe;

  assign req_vec      = {ld_req, cpu_req};
  assign we_vec       = {ld_we, cpu_we};
  assign addr_vec[0]  = cpu_addr;
  assign addr_vec[1]  = ld_addr;
  assign wdata_vec[0] = cpu_wdata;
  assign wdata_vec[1] = ld_wdata;

  // On a tie the requester that did not win last time goes first.
  always_comb begin
    any_req = |req_vec;
    winner  = (&req_vec) ? ~last_grant_q : req_vec[1];
  end

  assign access_last = (state_q == S_ACCESS) && (cnt_q == '0);

  // Strobe flops are loaded with the value wanted in the state being entered.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    busy_d       = 1'b0;
    ce_d         = 1'b1;
    oe_d         = 1'b1;
    wen_d        = 1'b1;
    ub_d         = 1'b1;
    lb_d         = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          state_d      = S_SETUP;
          addr_d       = addr_vec[winner];
          we_d         = we_vec[winner];
          wdata_d      = wdata_vec[winner];
          grant_d      = winner;
          last_grant_d = winner;
          busy_d       = 1'b1;
          ce_d         = 1'b0;
          ub_d         = 1'b0;
          lb_d         = 1'b0;
          oe_d         = we_vec[winner];
        end
      end
      S_SETUP: begin
        state_d = S_ACCESS;
        cnt_d   = CNT_LOAD;
        busy_d  = 1'b1;
        ce_d    = 1'b0;
        ub_d    = 1'b0;
        lb_d    = 1'b0;
        oe_d    = we_q;
        wen_d   = ~we_q;
      end
      S_ACCESS: begin
        busy_d = 1'b1;
        ce_d   = 1'b0;
        ub_d   = 1'b0;
        lb_d   = 1'b0;
        if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
          oe_d  = we_q;
          wen_d = ~we_q;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      busy_q       <= 1'b0;
      ce_q         <= 1'b1;
      oe_q         <= 1'b1;
      wen_q        <= 1'b1;
      ub_q         <= 1'b1;
      lb_q         <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      busy_q       <= busy_d;
      ce_q         <= ce_d;
      oe_q         <= oe_d;
      wen_q        <= wen_d;
      ub_q         <= ub_d;
      lb_q         <= lb_d;
    end
  end

  // Per-requester read-data and ready registers; only the granted port is touched.
  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    logic [15:0] rdata_q, rdata_d;
    logic        ready_q, ready_d;
    logic        hit;

    assign hit = access_last && (grant_q == 1'(gi));

    always_comb begin
      ready_d = hit;
      rdata_d = rdata_q;
      if (hit && !we_q) begin
        rdata_d = Mem_bus;
      end
    end

    always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
        rdata_q <= '0;
        ready_q <= 1'b0;
      end else begin
        rdata_q <= rdata_d;
        ready_q <= ready_d;
      end
    end
  end

  // Write data is driven from SETUP through DONE so it covers setup and hold.
  assign bus_oe  = we_q && (state_q != S_IDLE);
  assign Mem_bus = bus_oe ? wdata_q : {16{1'bz}};

  assign cpu_rdata = g_port[0].rdata_q;
  assign cpu_ready = g_port[0].ready_q;
  assign ld_rdata  = g_port[1].rdata_q;
  assign ld_ready  = g_port[1].ready_q;
  assign grant     = grant_q;
  assign busy      = busy_q;
  assign A         = addr_q;
  assign CE_out    = ce_q;
  assign OE_out    = oe_q;
  assign WE_out    = wen_q;
  assign UB_out    = ub_q;
  assign LB_out    = lb_q;

endmodule

// File: tb/tb_sram_arbiter_ctrl.sv
// Bench for sram_arbiter_ctrl: SRAM model, vector table, scoreboard of ready pulses,
// hand-written arbitration/reset sequences and a WAIT_CYCLES=1 instance.
module tb_sram_arbiter_ctrl;
  localparam int W  = 2;
  localparam int AW = 20;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic          Reset;
  logic          cpu_req, cpu_we, ld_req, ld_we;
  logic [AW-1:0] cpu_addr, ld_addr;
  logic [15:0]   cpu_wdata, ld_wdata;
  logic [15:0]   cpu_rdata, ld_rdata;
  logic          cpu_ready, ld_ready, grant, busy;
  logic [AW-1:0] A;
  logic          CE_out, OE_out, WE_out, UB_out, LB_out;
  wire  [15:0]   Mem_bus;

  sram_arbiter_ctrl #(.WAIT_CYCLES(W), .ADDR_W(AW)) dut (
    .Clk(Clk), .Reset(Reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_rdata(ld_rdata), .ld_ready(ld_ready),
    .grant(grant), .busy(busy), .A(A),
    .CE_out(CE_out), .OE_out(OE_out), .WE_out(WE_out), .UB_out(UB_out), .LB_out(LB_out),
    .Mem_bus(Mem_bus)
  );

  // Second instance built with a single ACCESS cycle; its SRAM returns a function of A.
  logic          cpu_req_1, cpu_we_1, ld_req_1, ld_we_1;
  logic [AW-1:0] cpu_addr_1, ld_addr_1;
  logic [15:0]   cpu_wdata_1, ld_wdata_1;
  logic [15:0]   cpu_rdata_1, ld_rdata_1;
  logic          cpu_ready_1, ld_ready_1, grant_1, busy_1;
  logic [AW-1:0] A_1;
  logic          CE_1, OE_1, WE_1, UB_1, LB_1;
  wire  [15:0]   bus_1;

  sram_arbiter_ctrl #(.WAIT_CYCLES(1), .ADDR_W(AW)) dut_w1 (
    .Clk(Clk), .Reset(Reset),
    .cpu_req(cpu_req_1), .cpu_we(cpu_we_1), .cpu_addr(cpu_addr_1), .cpu_wdata(cpu_wdata_1),
    .cpu_rdata(cpu_rdata_1), .cpu_ready(cpu_ready_1),
    .ld_req(ld_req_1), .ld_we(ld_we_1), .ld_addr(ld_addr_1), .ld_wdata(ld_wdata_1),
    .ld_rdata(ld_rdata_1), .ld_ready(ld_ready_1),
    .grant(grant_1), .busy(busy_1), .A(A_1),
    .CE_out(CE_1), .OE_out(OE_1), .WE_out(WE_1), .UB_out(UB_1), .LB_out(LB_1),
    .Mem_bus(bus_1)
  );

  // Asynchronous SRAM model: reads are combinational, writes sampled on the falling clock.
  logic [15:0] mem [0:1023];
  logic        sram_drv, sram_drv_1;
  assign sram_drv   = !CE_out && !OE_out && WE_out;
  assign Mem_bus    = sram_drv ? mem[A[9:0]] : 16'hzzzz;
  assign sram_drv_1 = !CE_1 && !OE_1 && WE_1;
  assign bus_1      = sram_drv_1 ? (16'hA5C3 ^ {6'b0, A_1[9:0]}) : 16'hzzzz;

  typedef struct {
    bit          who;
    bit          we;
    logic [19:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
  } vec_t;

  typedef struct {
    bit          who;
    bit          is_read;
    logic [15:0] rdata;
    int          gap;
  } exp_t;

  vec_t        vecs [8];
  exp_t        sbq [$];
  logic [15:0] exp_rd [2];

  int            n_cmp, n_fail;
  int            cyc, last_ready_cyc, ready_cnt;
  int            oe_lo, we_lo;
  bit            got_ready, a_bad, bus_bad, a_glitch;
  logic [AW-1:0] cur_addr, prev_a;
  logic [15:0]   cur_wdata;
  bit            prev_busy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One clock step: update SRAM, watch strobe rules, pop the scoreboard on ready pulses.
  task automatic tick();
    exp_t e;
    @(negedge Clk);
    cyc++;
    if (!CE_out && !WE_out) mem[A[9:0]] = Mem_bus;
    chk("strobe_excl", 32'(!WE_out && !OE_out), 32'd0);
    chk("strobe_excl_w1", 32'(!WE_1 && !OE_1), 32'd0);
    if (!OE_out) oe_lo++;
    if (!WE_out) begin
      we_lo++;
      if (Mem_bus !== cur_wdata) bus_bad = 1'b1;
    end
    if (!CE_out && A !== cur_addr) a_bad = 1'b1;
    if (A !== prev_a && !(busy && !prev_busy)) a_glitch = 1'b1;
    prev_a    = A;
    prev_busy = busy;
    if (cpu_ready || ld_ready) begin
      ready_cnt++;
      got_ready = 1'b1;
      if (sbq.size() == 0) begin
        chk("unexpected_ready", {30'b0, cpu_ready, ld_ready}, 32'd0);
      end else begin
        e = sbq.pop_front();
        chk("ready_who", {30'b0, cpu_ready, ld_ready}, e.who ? 32'd1 : 32'd2);
        if (e.is_read) exp_rd[e.who] = e.rdata;
        chk("rdata_cpu", {16'b0, cpu_rdata}, {16'b0, exp_rd[0]});
        chk("rdata_ld", {16'b0, ld_rdata}, {16'b0, exp_rd[1]});
        if (e.gap != 0) chk("ready_gap", 32'(cyc - last_ready_cyc), 32'(e.gap));
      end
      last_ready_cyc = cyc;
    end
  endtask

  task automatic assert_reset();
    Reset     = 1'b0;
    cpu_req   = 1'b0;
    ld_req    = 1'b0;
    cpu_req_1 = 1'b0;
    sbq.delete();
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    #1;
    prev_a    = '0;
    prev_busy = 1'b0;
  endtask

  task automatic release_reset();
    Reset = 1'b1;
    tick();
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    cur_addr  = v.addr;
    cur_wdata = v.wdata;
    oe_lo     = 0;
    we_lo     = 0;
    a_bad     = 1'b0;
    bus_bad   = 1'b0;
    got_ready = 1'b0;
    if (v.who) begin
      ld_req = 1'b1; ld_we = v.we; ld_addr = v.addr; ld_wdata = v.wdata;
    end else begin
      cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
    end
    sbq.push_back('{who: v.who, is_read: !v.we, rdata: v.rdata, gap: 0});
    n = 0;
    while (!got_ready && n < 20) begin
      tick();
      n++;
    end
    cpu_req = 1'b0;
    ld_req  = 1'b0;
    $display("txn who=%0d we=%0d addr=%05h wdata=%04h latency=%0d oe_lo=%0d we_lo=%0d",
             v.who, v.we, v.addr, v.wdata, n, oe_lo, we_lo);
    chk("latency", 32'(n), 32'(W + 2));
    chk("oe_low_cycles", 32'(oe_lo), v.we ? 32'd0 : 32'(W + 1));
    chk("we_low_cycles", 32'(we_lo), v.we ? 32'(W) : 32'd0);
    chk("addr_during_access", 32'(a_bad), 32'd0);
    chk("bus_during_we", 32'(bus_bad), 32'd0);
    tick();
  endtask

  initial begin
    int n, rc0;
    n_cmp = 0; n_fail = 0; cyc = 0; last_ready_cyc = 0; ready_cnt = 0;
    oe_lo = 0; we_lo = 0; got_ready = 0; a_bad = 0; bus_bad = 0; a_glitch = 0;
    cur_addr = '0; cur_wdata = '0;
    cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    ld_we = 0; ld_addr = '0; ld_wdata = '0;
    cpu_we_1 = 0; cpu_addr_1 = '0; cpu_wdata_1 = '0;
    ld_req_1 = 0; ld_we_1 = 0; ld_addr_1 = '0; ld_wdata_1 = '0;
    mem[11] = 16'hBEEF;

    vecs[0] = '{who: 1'b0, we: 1'b0, addr: 20'h0000B, wdata: 16'h0000, rdata: 16'hBEEF};
    vecs[1] = '{who: 1'b1, we: 1'b1, addr: 20'h00014, wdata: 16'h1234, rdata: 16'h0000};
    vecs[2] = '{who: 1'b0, we: 1'b0, addr: 20'h00014, wdata: 16'h0000, rdata: 16'h1234};
    vecs[3] = '{who: 1'b0, we: 1'b1, addr: 20'h8002A, wdata: 16'h5A5A, rdata: 16'h0000};
    vecs[4] = '{who: 1'b1, we: 1'b0, addr: 20'h8002A, wdata: 16'h0000, rdata: 16'h5A5A};
    vecs[5] = '{who: 1'b1, we: 1'b1, addr: 20'h003FF, wdata: 16'hC3A5, rdata: 16'h0000};
    vecs[6] = '{who: 1'b0, we: 1'b0, addr: 20'h003FF, wdata: 16'h0000, rdata: 16'hC3A5};
    vecs[7] = '{who: 1'b1, we: 1'b0, addr: 20'h0000B, wdata: 16'h0000, rdata: 16'hBEEF};

    // Reset values.
    assert_reset();
    repeat (2) tick();
    chk("rst_strobes", {27'b0, CE_out, OE_out, WE_out, UB_out, LB_out}, 32'h1F);
    chk("rst_addr", 32'(A), 32'd0);
    chk("rst_busy_grant", {30'b0, busy, grant}, 32'd0);
    chk("rst_ready", {30'b0, cpu_ready, ld_ready}, 32'd0);
    chk("rst_rdata", {cpu_rdata, ld_rdata}, 32'd0);
    chk("w1_rst_flags", {23'b0, CE_1, OE_1, WE_1, UB_1, LB_1, busy_1, grant_1, ld_ready_1, cpu_ready_1},
        32'h1F0);
    chk("w1_rst_addr", 32'(A_1), 32'd0);
    chk("w1_rst_ld_rdata", 32'(ld_rdata_1), 32'd0);
    release_reset();

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);
    chk("a_only_in_setup_tbl", 32'(a_glitch), 32'd0);

    // Both requesters held high from reset: grants alternate 0,1,0,1 with one IDLE gap.
    assert_reset();
    repeat (2) tick();
    release_reset();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 20'h0000B;
    ld_req  = 1'b1; ld_we  = 1'b0; ld_addr  = 20'h00014;
    sbq.push_back('{who: 1'b0, is_read: 1'b1, rdata: 16'hBEEF, gap: 0});
    sbq.push_back('{who: 1'b1, is_read: 1'b1, rdata: 16'h1234, gap: W + 3});
    sbq.push_back('{who: 1'b0, is_read: 1'b1, rdata: 16'hBEEF, gap: W + 3});
    sbq.push_back('{who: 1'b1, is_read: 1'b1, rdata: 16'h1234, gap: W + 3});
    rc0 = ready_cnt;
    n = 0;
    while (ready_cnt < rc0 + 4 && n < 60) begin
      tick();
      n++;
    end
    cpu_req = 1'b0;
    ld_req  = 1'b0;
    $display("txn both_held readies=%0d cycles=%0d", ready_cnt - rc0, n);
    chk("both_held_count", 32'(ready_cnt - rc0), 32'd4);
    tick();

    // CPU holds request, loader idle: back-to-back every W+3 cycles.
    a_glitch = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 20'h00014;
    sbq.push_back('{who: 1'b0, is_read: 1'b1, rdata: 16'h1234, gap: 0});
    sbq.push_back('{who: 1'b0, is_read: 1'b1, rdata: 16'h1234, gap: W + 3});
    sbq.push_back('{who: 1'b0, is_read: 1'b1, rdata: 16'h1234, gap: W + 3});
    rc0 = ready_cnt;
    n = 0;
    while (ready_cnt < rc0 + 3 && n < 60) begin
      tick();
      n++;
    end
    cpu_req = 1'b0;
    $display("txn cpu_held readies=%0d cycles=%0d", ready_cnt - rc0, n);
    chk("cpu_held_count", 32'(ready_cnt - rc0), 32'd3);
    chk("a_only_in_setup", 32'(a_glitch), 32'd0);
    tick();

    // Reset in the first ACCESS cycle of a write aborts it immediately.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 20'h00040; cpu_wdata = 16'h7777;
    repeat (2) tick();
    chk("abort_we_low_before", 32'(WE_out), 32'd0);
    assert_reset();
    chk("abort_strobes", {27'b0, CE_out, OE_out, WE_out, UB_out, LB_out}, 32'h1F);
    chk("abort_bus_released", 32'(Mem_bus === 16'h7777), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    $display("txn reset_abort we=%0b ce=%0b busy=%0b", WE_out, CE_out, busy);
    rc0 = ready_cnt;
    repeat (2) tick();
    release_reset();
    repeat (3) tick();
    chk("abort_no_ready", 32'(ready_cnt - rc0), 32'd0);
    run_vec('{who: 1'b0, we: 1'b0, addr: 20'h0000B, wdata: 16'h0000, rdata: 16'hBEEF});

    // WAIT_CYCLES=1 build: read latency 3.
    cpu_req_1 = 1'b1; cpu_we_1 = 1'b0; cpu_addr_1 = 20'h00003;
    n = 0;
    while (!cpu_ready_1 && n < 10) begin
      tick();
      n++;
    end
    cpu_req_1 = 1'b0;
    $display("txn w1_read addr=00003 latency=%0d rdata=%04h", n, cpu_rdata_1);
    chk("w1_latency", 32'(n), 32'd3);
    chk("w1_rdata", 32'(cpu_rdata_1), 32'h0000A5C0);
    repeat (3) tick();
    chk("sb_drained", 32'(sbq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
